spi_master_controller: RTL and testbench

- SPI initiator (mode 0: CPOL=0, CPHA=0, MSB first) that drives sclk, cs and mosi and captures miso.
- It is the host-side counterpart to the SPI-slave datapath in the lab design (input conditioners, shift registers, FSM). Bench and FPGA top levels use it to issue frames to the SPI memory.
- Transfers one width-bit frame per start. Optionally holds cs low across consecutive frames, e.g. an address/command byte followed by a data byte.

---
 rtl/spi_master_controller.sv | 159 +++++++++++++++
 tb/tb_spi_master_controller.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_controller.sv
// SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, one width-bit frame per start.
// Latency: done pulses (2*width+1)*clkdiv clk cycles after the accepting edge.
// Backpressure: start is ignored while busy; keepCs parks cs low in HOLD for a follow-on frame.
module spi_master_controller #(
  parameter int width  = 8,
  parameter int clkdiv = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             keepCs,
  input  logic             release_cs,
  input  logic [width-1:0] txData,
  output logic [width-1:0] rxData,
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             cs,
  output logic             mosi,
  input  logic             miso
);

  localparam int CW = (clkdiv > 1) ? $clog2(clkdiv) : 1;
  localparam int BW = $clog2(width) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(clkdiv - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(width - 1);

  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TAIL, HOLD, GAP} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    hcnt, hcnt_n;
  logic [BW-1:0]    bitcnt, bitcnt_n;
  logic [width-1:0] tx_sh, tx_sh_n;
  logic [width-1:0] rx_sh, rx_sh_n;
  logic             keep, keep_n;
  logic [width-1:0] rxdata_n;
  logic             busy_n, done_n, sclk_n, cs_n, mosi_n;

  logic             half_end;
  logic [width-1:0] tx_next;
  logic [width-1:0] rx_next;

  // Shift helpers written without fixed slices so width=1 stays legal.
  assign half_end = (hcnt == HALF_LAST);
  assign tx_next  = tx_sh << 1;
  assign rx_next  = width'({rx_sh, miso});

  // State and output registers; reset aborts any frame without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      hcnt   <= '0;
      bitcnt <= '0;
      tx_sh  <= '0;
      rx_sh  <= '0;
      keep   <= 1'b0;
      rxData <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sclk   <= 1'b0;
      cs     <= 1'b1;
      mosi   <= 1'b0;
    end else begin
      state  <= state_n;
      hcnt   <= hcnt_n;
      bitcnt <= bitcnt_n;
      tx_sh  <= tx_sh_n;
      rx_sh  <= rx_sh_n;
      keep   <= keep_n;
      rxData <= rxdata_n;
      busy   <= busy_n;
      done   <= done_n;
      sclk   <= sclk_n;
      cs     <= cs_n;
      mosi   <= mosi_n;
    end
  end

  // Next-state logic: every timed state advances when the half-period counter wraps.
  always_comb begin
    state_n  = state;
    hcnt_n   = half_end ? '0 : hcnt + CW'(1);
    bitcnt_n = bitcnt;
    tx_sh_n  = tx_sh;
    rx_sh_n  = rx_sh;
    keep_n   = keep;
    rxdata_n = rxData;
    busy_n   = busy;
    done_n   = 1'b0;
    sclk_n   = sclk;
    cs_n     = cs;
    mosi_n   = mosi;

    case (state)
      IDLE, HOLD: begin
        hcnt_n = '0;
        if (start) begin
          // Frame acceptance: operands are captured here and never re-read.
          tx_sh_n  = txData;
          keep_n   = keepCs;
          busy_n   = 1'b1;
          cs_n     = 1'b0;
          mosi_n   = txData[width-1];
          bitcnt_n = '0;
          state_n  = LEAD;
        end else if (state == HOLD && release_cs) begin
          cs_n    = 1'b1;
          busy_n  = 1'b1;
          state_n = GAP;
        end
      end
      LEAD, LOW: begin
        if (half_end) begin
          sclk_n  = 1'b1;
          rx_sh_n = rx_next;
          state_n = HIGH;
        end
      end
      HIGH: begin
        if (half_end) begin
          sclk_n = 1'b0;
          if (bitcnt == BIT_LAST) begin
            state_n = TAIL;
          end else begin
            tx_sh_n  = tx_next;
            mosi_n   = tx_next[width-1];
            bitcnt_n = bitcnt + BW'(1);
            state_n  = LOW;
          end
        end
      end
      TAIL: begin
        if (half_end) begin
          done_n   = 1'b1;
          rxdata_n = rx_sh;
          if (keep) begin
            busy_n  = 1'b0;
            state_n = HOLD;
          end else begin
            cs_n    = 1'b1;
            state_n = GAP;
          end
        end
      end
      GAP: begin
        // cs-high spacing before the slave can see another frame.
        if (half_end) begin
          busy_n  = 1'b0;
          mosi_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_master_controller.sv
// Directed bench for spi_master_controller (width=8, clkdiv=2).
// Expected frames are queued at start; received frames are queued by a monitor at done.
// All checks are immediate assertions in the main sequence.
module tb_spi_master_controller;

  logic       clk;
  logic       reset;
  logic       start;
  logic       keepCs;
  logic       release_cs;
  logic [7:0] txData;
  logic [7:0] rxData;
  logic       busy;
  logic       done;
  logic       sclk;
  logic       cs;
  logic       mosi;
  logic       miso;

  logic       loopback;
  logic       miso_val;
  logic       cs_watch;

  int tests;
  int fails;

  // Monitor-owned state
  int         rise_cnt;
  int         done_cnt;
  int         cs_rise_bad;
  int         cs_break_cnt;
  logic [7:0] mosi_bits;
  logic       sclk_q;
  logic [7:0] obs_q[$];

  // Main-owned scoreboard
  logic [7:0] exp_q[$];

  assign miso = loopback ? mosi : miso_val;

  spi_master_controller #(.width(8), .clkdiv(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .keepCs     (keepCs),
    .release_cs (release_cs),
    .txData     (txData),
    .rxData     (rxData),
    .busy       (busy),
    .done       (done),
    .sclk       (sclk),
    .cs         (cs),
    .mosi       (mosi),
    .miso       (miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rise_cnt     = 0;
    done_cnt     = 0;
    cs_rise_bad  = 0;
    cs_break_cnt = 0;
    mosi_bits    = 8'h00;
    sclk_q       = 1'b0;
  end

  // Monitor: runs 1 ns after each edge, ahead of the main sequence's sample point.
  always @(posedge clk) begin
    #1;
    if (sclk === 1'b1 && sclk_q === 1'b0) begin
      rise_cnt  = rise_cnt + 1;
      mosi_bits = {mosi_bits[6:0], mosi};
      if (cs !== 1'b0) cs_rise_bad = cs_rise_bad + 1;
    end
    sclk_q = sclk;
    if (cs_watch && cs !== 1'b0 && done !== 1'b1) cs_break_cnt = cs_break_cnt + 1;
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      obs_q.push_back(rxData);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] data, input logic keep,
                          input logic [7:0] exp, input logic push);
    txData = data;
    keepCs = keep;
    start  = 1'b1;
    if (push) exp_q.push_back(exp);
    tick();
    start  = 1'b0;
    txData = 8'($urandom);
    keepCs = ~keep;
  endtask

  task automatic wait_done(input string tag);
    for (int n = 0; n < 200 && done !== 1'b1; n++) tick();
    chk(tag, 32'(done), 32'(1));
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 200 && busy !== 1'b0; n++) tick();
    chk(tag, 32'(busy), 32'(0));
  endtask

  task automatic sb_check(input string tag);
    chk({tag, "_avail"}, 32'(obs_q.size() != 0 && exp_q.size() != 0), 32'(1));
    if (obs_q.size() != 0 && exp_q.size() != 0)
      chk(tag, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
  endtask

  initial begin
    int rb;
    int db;
    int cb;
    tests      = 0;
    fails      = 0;
    loopback   = 1'b0;
    miso_val   = 1'b0;
    cs_watch   = 1'b0;
    reset      = 1'b1;
    start      = 1'b0;
    keepCs     = 1'b0;
    release_cs = 1'b0;
    txData     = 8'h00;

    // Reset with inputs toggling
    for (int i = 0; i < 3; i++) begin
      start      = i[0];
      keepCs     = ~i[0];
      release_cs = 1'b1;
      txData     = 8'($urandom);
      miso_val   = i[0];
      tick();
    end
    chk("rst_cs", 32'(cs), 32'(1));
    chk("rst_sclk", 32'(sclk), 32'(0));
    chk("rst_mosi", 32'(mosi), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_rxData", 32'(rxData), 32'(0));
    start      = 1'b0;
    release_cs = 1'b0;
    reset      = 1'b0;
    tick();

    // Loopback 0xA5, cycle-accurate frame timing
    loopback = 1'b1;
    rb = rise_cnt;
    do_start(8'hA5, 1'b0, 8'hA5, 1'b1);
    chk("lb_e0_cs", 32'(cs), 32'(0));
    chk("lb_e0_busy", 32'(busy), 32'(1));
    chk("lb_e0_mosi", 32'(mosi), 32'(1));
    repeat (33) tick();
    chk("lb_e33_done", 32'(done), 32'(0));
    chk("lb_e33_cs", 32'(cs), 32'(0));
    tick();
    chk("lb_e34_done", 32'(done), 32'(1));
    chk("lb_e34_cs", 32'(cs), 32'(1));
    chk("lb_e34_busy", 32'(busy), 32'(1));
    sb_check("lb_rx");
    tick();
    chk("lb_e35_done", 32'(done), 32'(0));
    chk("lb_e35_busy", 32'(busy), 32'(1));
    tick();
    chk("lb_e36_busy", 32'(busy), 32'(0));
    chk("lb_e36_mosi", 32'(mosi), 32'(0));
    chk("lb_rises", 32'(rise_cnt - rb), 32'(8));
    chk("lb_mosi_bits", 32'(mosi_bits), 32'(8'hA5));

    // Constant miso, with a start pulse during the frame that must be ignored
    loopback = 1'b0;
    miso_val = 1'b1;
    db = done_cnt;
    do_start(8'h00, 1'b0, 8'hFF, 1'b1);
    repeat (3) tick();
    start  = 1'b1;
    txData = 8'h55;
    keepCs = 1'b1;
    tick();
    start  = 1'b0;
    wait_done("m1_done");
    tick();
    sb_check("m1_rx");
    wait_idle("m1_idle");
    repeat (4) tick();
    chk("m1_one_done", 32'(done_cnt - db), 32'(1));
    chk("m1_cs", 32'(cs), 32'(1));
    miso_val = 1'b0;
    do_start(8'h00, 1'b0, 8'h00, 1'b1);
    wait_done("m0_done");
    tick();
    sb_check("m0_rx");
    wait_idle("m0_idle");

    // Two frames with cs held low between them
    loopback = 1'b1;
    rb = rise_cnt;
    cb = cs_break_cnt;
    do_start(8'h3C, 1'b1, 8'h3C, 1'b1);
    cs_watch = 1'b1;
    wait_done("h1_done");
    chk("h1_busy", 32'(busy), 32'(0));
    chk("h1_cs", 32'(cs), 32'(0));
    repeat (5) tick();
    chk("hold_busy", 32'(busy), 32'(0));
    chk("hold_cs", 32'(cs), 32'(0));
    chk("hold_sclk", 32'(sclk), 32'(0));
    sb_check("h1_rx");
    do_start(8'hC3, 1'b0, 8'hC3, 1'b1);
    wait_done("h2_done");
    cs_watch = 1'b0;
    chk("h_cs_low", 32'(cs_break_cnt - cb), 32'(0));
    chk("h_rises", 32'(rise_cnt - rb), 32'(16));
    tick();
    sb_check("h2_rx");
    wait_idle("h2_idle");

    // Release from HOLD
    do_start(8'h81, 1'b1, 8'h81, 1'b1);
    wait_done("r1_done");
    tick();
    sb_check("r1_rx");
    chk("r_hold_mosi", 32'(mosi), 32'(1));
    rb = rise_cnt;
    db = done_cnt;
    release_cs = 1'b1;
    tick();
    release_cs = 1'b0;
    chk("r_cs", 32'(cs), 32'(1));
    chk("r_busy0", 32'(busy), 32'(1));
    chk("r_gap_mosi", 32'(mosi), 32'(1));
    tick();
    chk("r_busy1", 32'(busy), 32'(1));
    tick();
    chk("r_busy2", 32'(busy), 32'(0));
    chk("r_idle_mosi", 32'(mosi), 32'(0));
    chk("r_no_rise", 32'(rise_cnt - rb), 32'(0));
    chk("r_no_done", 32'(done_cnt - db), 32'(0));

    // Release in IDLE does nothing
    release_cs = 1'b1;
    tick();
    release_cs = 1'b0;
    chk("ri_busy", 32'(busy), 32'(0));
    chk("ri_cs", 32'(cs), 32'(1));

    // start together with release in HOLD: start wins
    do_start(8'h42, 1'b1, 8'h42, 1'b1);
    wait_done("sr1_done");
    tick();
    sb_check("sr1_rx");
    cb = cs_break_cnt;
    release_cs = 1'b1;
    do_start(8'h99, 1'b0, 8'h99, 1'b1);
    release_cs = 1'b0;
    chk("sr_cs", 32'(cs), 32'(0));
    chk("sr_busy", 32'(busy), 32'(1));
    cs_watch = 1'b1;
    wait_done("sr2_done");
    cs_watch = 1'b0;
    chk("sr_cs_low", 32'(cs_break_cnt - cb), 32'(0));
    tick();
    sb_check("sr2_rx");
    wait_idle("sr2_idle");

    // Reset mid-frame after the third sclk rise
    rb = rise_cnt;
    db = done_cnt;
    do_start(8'hF0, 1'b0, 8'h00, 1'b0);
    for (int n = 0; n < 100 && (rise_cnt - rb) < 3; n++) tick();
    chk("mr_rises", 32'(rise_cnt - rb), 32'(3));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_cs", 32'(cs), 32'(1));
    chk("mr_sclk", 32'(sclk), 32'(0));
    chk("mr_busy", 32'(busy), 32'(0));
    chk("mr_done", 32'(done), 32'(0));
    chk("mr_rxData", 32'(rxData), 32'(0));
    repeat (40) tick();
    chk("mr_no_done", 32'(done_cnt - db), 32'(0));
    chk("mr_rxData_hold", 32'(rxData), 32'(0));

    // Clean frame after the abort
    rb = rise_cnt;
    do_start(8'h5A, 1'b0, 8'h5A, 1'b1);
    wait_done("pr_done");
    tick();
    sb_check("pr_rx");
    wait_idle("pr_idle");
    chk("pr_rises", 32'(rise_cnt - rb), 32'(8));
    chk("pr_mosi_bits", 32'(mosi_bits), 32'(8'h5A));

    chk("cs_at_rises", 32'(cs_rise_bad), 32'(0));
    chk("sb_exp_left", 32'(exp_q.size()), 32'(0));
    chk("sb_obs_left", 32'(obs_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
